adder_rr_arbiter: RTL

//   Shares one full_adder_2b datapath between two requesters (0 and 1).

---
 rtl/adder_rr_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter
//   Shares a single 2-bit adder between two requesters.
//   - Arbitration is round-robin.
//   - Operands and the result are registered.
//   - Each requester uses a req/ack handshake.
//   - One operation takes three cycles: sampled in IDLE, computed in CALC,
//     and reported in RESP.
//
// Optional feature macro: ADD_ARB_STATS_EN
//   When defined, adds saturating per-requester grant counters
//   (gnt_cnt0/gnt_cnt1).
//
// Ports
//   clk, rst_n            clock (rising edge); async active-low reset
//   req0, a0, b0          requester 0 request and operands (held until ack0)
//   req1, a1, b1          requester 1 request and operands (held until ack1)
//   ack0, ack1            one-cycle pulse when sum holds that requester's result
//   sum                   registered a+b of the granted request, carry in bit 2
//   sum_id                requester that owns sum
//   sum_valid             high in RESP (ack0 | ack1)
//   busy                  high in CALC and RESP
//   gnt_cnt0, gnt_cnt1    grants issued per requester (ADD_ARB_STATS_EN only)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; a request seen on the edge is granted and latched
// CALC  | adder evaluates latched operands; result registered on the edge
// RESP  | sum valid, ack pulses for the granted requester

module full_adder_2b (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic [1:0] s,
   output logic       cout
);
   logic c1;

   assign s[0] = a[0] ^ b[0] ^ cin;
   assign c1   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
   assign s[1] = a[1] ^ b[1] ^ c1;
   assign cout = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
endmodule

module adder_rr_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [1:0]       a0,
   input  logic [1:0]       b0,
   output logic             ack0,
   input  logic             req1,
   input  logic [1:0]       a1,
   input  logic [1:0]       b1,
   output logic             ack1,
   output logic [2:0]       sum,
   output logic             sum_id,
   output logic             sum_valid,
   output logic             busy
`ifdef ADD_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] op_a, op_b;
   logic       gid;
   logic       last_gnt;
   logic       take;
   logic       win;
   logic [1:0] add_s;
   logic       add_c;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("adder_rr_arbiter: CNT_W must be at least 1");
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      // On a tie the requester that did not win last time is chosen.
      win       = (req0 & req1) ? ~last_gnt : req1;
      case (state)
         IDLE: begin
            if (req0 | req1) begin
               take      = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a     <= 2'd0;
         op_b     <= 2'd0;
         gid      <= 1'b0;
         last_gnt <= 1'b1;
      end else if (take) begin
         op_a     <= win ? a1 : a0;
         op_b     <= win ? b1 : b0;
         gid      <= win;
         last_gnt <= win;
      end
   end

   full_adder_2b u_add (
      .a    (op_a),
      .b    (op_b),
      .cin  (1'b0),
      .s    (add_s),
      .cout (add_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum    <= 3'd0;
         sum_id <= 1'b0;
      end else if (state == CALC) begin
         sum    <= {add_c, add_s};
         sum_id <= gid;
      end
   end

   assign sum_valid = (state == RESP);
   assign busy      = (state == CALC) || (state == RESP);
   assign ack0      = sum_valid & ~gid;
   assign ack1      = sum_valid &  gid;

`ifdef ADD_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else if (take) begin
         if (!win && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
         if ( win && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
      end
   end
`endif

endmodule
